dmem_responder: RTL and testbench



---
 rtl/dmem_responder.sv | 143 ++++++++++++++
 tb/tb_dmem_responder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory target for the CPU data port: a word RAM below IO_BASE and an I/O page
// (LEDs, synchronized switches, debounced button, timer with compare) at and above it.
module dmem_responder #(
    parameter int          DEPTH_LOG2      = 7,
    parameter logic [15:0] IO_BASE         = 16'hFF00,
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] dmemaddr,
    input  logic [15:0] dmemwdata,
    input  logic        dmemwrite,
    input  logic        dmemread,
    output logic [15:0] dmemrdata,
    input  logic [7:0]  switches,
    input  logic        button,
    output logic [7:0]  leds,
    output logic        timer_flag
);
    localparam logic [2:0] SEL_LED  = 3'd0;
    localparam logic [2:0] SEL_SW   = 3'd1;
    localparam logic [2:0] SEL_BTN  = 3'd2;
    localparam logic [2:0] SEL_TCNT = 3'd3;
    localparam logic [2:0] SEL_TCMP = 3'd4;
    localparam logic [2:0] SEL_TFLG = 3'd5;

    logic [15:0]           r_ram [0:(1<<DEPTH_LOG2)-1];
    logic [7:0]            r_leds;
    logic [7:0]            r_sw_s1;
    logic [7:0]            r_sw_s2;
    logic                  r_btn_s1;
    logic                  r_btn_s2;
    logic                  r_stable;
    logic                  r_sticky;
    logic [15:0]           r_dcnt;
    logic [15:0]           r_tcnt;
    logic [15:0]           r_tcmp;
    logic                  r_flag;

    logic                  w_is_io;
    logic [2:0]            w_sel;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_io_wr;
    logic                  w_deb_done;
    logic                  w_btn_rise;
    logic                  w_match;
    logic [15:0]           w_rdata;

    assign w_is_io    = (dmemaddr >= IO_BASE);
    assign w_sel      = dmemaddr[3:1];
    assign w_idx      = dmemaddr[DEPTH_LOG2:1];
    assign w_io_wr    = dmemwrite && w_is_io;
    assign w_deb_done = (r_btn_s2 != r_stable) && (r_dcnt == DEBOUNCE_CYCLES - 16'd1);
    assign w_btn_rise = w_deb_done && r_btn_s2;
    assign w_match    = (r_tcnt == r_tcmp);

    assign leds       = r_leds;
    assign timer_flag = r_flag;
    assign dmemrdata  = w_rdata;

    // RAM is never cleared, but stores are still blocked while reset is high.
    always_ff @(posedge clock) begin
        if (dmemwrite && !reset && !w_is_io)
            r_ram[w_idx] <= dmemwdata;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sw_s1  <= 8'h00;
            r_sw_s2  <= 8'h00;
            r_btn_s1 <= 1'b0;
            r_btn_s2 <= 1'b0;
        end else begin
            r_sw_s1  <= switches;
            r_sw_s2  <= r_sw_s1;
            r_btn_s1 <= button;
            r_btn_s2 <= r_btn_s1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_dcnt   <= 16'h0000;
            r_stable <= 1'b0;
            r_sticky <= 1'b0;
        end else begin
            if (r_btn_s2 == r_stable) begin
                r_dcnt <= 16'h0000;
            end else if (w_deb_done) begin
                r_stable <= r_btn_s2;
                r_dcnt   <= 16'h0000;
            end else begin
                r_dcnt <= r_dcnt + 16'd1;
            end
            if (w_btn_rise)
                r_sticky <= 1'b1;
            else if (w_io_wr && w_sel == SEL_BTN && dmemwdata[1])
                r_sticky <= 1'b0;
        end
    end

    // Compare uses the counter value before this edge's increment or load.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_leds <= 8'h00;
            r_tcnt <= 16'h0000;
            r_tcmp <= 16'hFFFF;
            r_flag <= 1'b0;
        end else begin
            if (w_io_wr && w_sel == SEL_LED)
                r_leds <= dmemwdata[7:0];
            if (w_io_wr && w_sel == SEL_TCNT)
                r_tcnt <= dmemwdata;
            else
                r_tcnt <= r_tcnt + 16'd1;
            if (w_io_wr && w_sel == SEL_TCMP)
                r_tcmp <= dmemwdata;
            if (w_match)
                r_flag <= 1'b1;
            else if (w_io_wr && w_sel == SEL_TFLG && dmemwdata[0])
                r_flag <= 1'b0;
        end
    end

    always_comb begin
        w_rdata = 16'h0000;
        if (dmemread) begin
            if (!w_is_io) begin
                w_rdata = r_ram[w_idx];
            end else begin
                case (w_sel)
                    SEL_LED:  w_rdata = {8'h00, r_leds};
                    SEL_SW:   w_rdata = {8'h00, r_sw_s2};
                    SEL_BTN:  w_rdata = {14'b0, r_sticky, r_stable};
                    SEL_TCNT: w_rdata = r_tcnt;
                    SEL_TCMP: w_rdata = r_tcmp;
                    SEL_TFLG: w_rdata = {15'b0, r_flag};
                    default:  w_rdata = 16'h0000;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed test-plan steps, then random traffic, all checked
// every cycle against a behavioural model of the memory map.
module tb_dmem_responder;
    localparam int          DL2 = 7;
    localparam logic [15:0] IOB = 16'hFF00;
    localparam int          DEB = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] dmemaddr;
    logic [15:0] dmemwdata;
    logic        dmemwrite;
    logic        dmemread;
    logic [15:0] dmemrdata;
    logic [7:0]  switches;
    logic        button;
    logic [7:0]  leds;
    logic        timer_flag;

    always #5 clock = ~clock;

    dmem_responder #(
        .DEPTH_LOG2(DL2),
        .IO_BASE(IOB),
        .DEBOUNCE_CYCLES(16'(DEB))
    ) dut (
        .clock(clock),
        .reset(reset),
        .dmemaddr(dmemaddr),
        .dmemwdata(dmemwdata),
        .dmemwrite(dmemwrite),
        .dmemread(dmemread),
        .dmemrdata(dmemrdata),
        .switches(switches),
        .button(button),
        .leds(leds),
        .timer_flag(timer_flag)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [15:0] m_ram [0:(1<<DL2)-1];
    logic [7:0]  m_leds;
    logic [15:0] m_tcnt;
    logic [15:0] m_tcmp;
    logic        m_flag;
    logic [7:0]  m_sw [0:1];
    logic        m_btn [0:1];
    logic        m_stable;
    logic        m_sticky;
    int          m_run;

    function automatic logic [15:0] m_read(logic [15:0] a, logic rd);
        if (!rd) return 16'h0000;
        if (a < IOB) return m_ram[a[DL2:1]];
        case (a[3:1])
            3'd0:    return {8'h00, m_leds};
            3'd1:    return {8'h00, m_sw[1]};
            3'd2:    return {14'b0, m_sticky, m_stable};
            3'd3:    return m_tcnt;
            3'd4:    return m_tcmp;
            3'd5:    return {15'b0, m_flag};
            default: return 16'h0000;
        endcase
    endfunction

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        logic [15:0] a = dmemaddr;
        logic        io_wr = dmemwrite && (a >= IOB);
        logic        rise = 1'b0;
        if (reset) begin
            m_leds = 8'h00; m_tcnt = 16'h0000; m_tcmp = 16'hFFFF; m_flag = 1'b0;
            m_sw[0] = 8'h00; m_sw[1] = 8'h00; m_btn[0] = 1'b0; m_btn[1] = 1'b0;
            m_stable = 1'b0; m_sticky = 1'b0; m_run = 0;
            return;
        end
        // A new level is accepted once it has disagreed with stable for DEB edges in a row.
        if (m_btn[1] != m_stable) m_run++;
        else m_run = 0;
        if (m_run == DEB) begin
            rise = !m_stable;
            m_stable = m_btn[1];
            m_run = 0;
        end
        if (rise) m_sticky = 1'b1;
        else if (io_wr && a[3:1] == 3'd2 && dmemwdata[1]) m_sticky = 1'b0;
        m_btn[1] = m_btn[0]; m_btn[0] = button;
        m_sw[1] = m_sw[0];   m_sw[0] = switches;
        if (m_tcnt == m_tcmp) m_flag = 1'b1;
        else if (io_wr && a[3:1] == 3'd5 && dmemwdata[0]) m_flag = 1'b0;
        if (io_wr && a[3:1] == 3'd3) m_tcnt = dmemwdata;
        else m_tcnt = m_tcnt + 16'd1;
        if (io_wr && a[3:1] == 3'd4) m_tcmp = dmemwdata;
        if (io_wr && a[3:1] == 3'd0) m_leds = dmemwdata[7:0];
        if (dmemwrite && a < IOB) m_ram[a[DL2:1]] = dmemwdata;
    endtask

    task automatic chk(string tag, logic [15:0] got, logic [15:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(logic [15:0] a, logic rd, logic wr, logic [15:0] wd);
        dmemaddr = a; dmemread = rd; dmemwrite = wr; dmemwdata = wd;
        #1;
    endtask

    task automatic tick();
        chk("rdata", dmemrdata, m_read(dmemaddr, dmemread));
        chk("leds", {8'h00, leds}, {8'h00, m_leds});
        chk("timer_flag", {15'b0, timer_flag}, {15'b0, m_flag});
        @(posedge clock);
        model_edge();
        #1;
    endtask

    initial begin
        logic [15:0] wrap_exp [0:2];
        reset = 1'b1; switches = 8'h00; button = 1'b0;
        dmemaddr = 16'h0000; dmemwdata = 16'h0000; dmemwrite = 1'b0; dmemread = 1'b0;
        repeat (2) begin @(posedge clock); model_edge(); end
        #1; reset = 1'b0;

        for (int i = 0; i < (1 << DL2); i++) begin
            drive(16'(i * 2), 1'b0, 1'b1, 16'($urandom));
            tick();
        end

        // store issued during reset must be dropped
        reset = 1'b1;
        drive(16'h0010, 1'b1, 1'b1, 16'hDEAD);
        tick();
        reset = 1'b0;

        for (int i = 0; i < 3; i++) begin
            drive(16'hFF06, 1'b1, 1'b0, 16'h0000);
            chk("tcnt_after_reset", dmemrdata, 16'(i));
            tick();
        end
        drive(16'hFF08, 1'b1, 1'b0, 16'h0000);
        chk("tcmp_reset", dmemrdata, 16'hFFFF);
        chk("leds_reset", {8'h00, leds}, 16'h0000);
        tick();
        drive(16'h0010, 1'b1, 1'b0, 16'h0000);
        chk("ram_reset_write_dropped", {15'b0, dmemrdata == 16'hDEAD}, 16'h0000);
        tick();

        drive(16'h0004, 1'b0, 1'b1, 16'h1234); tick();
        drive(16'h0104, 1'b0, 1'b1, 16'h5678); tick();
        drive(16'h0004, 1'b1, 1'b0, 16'h0000);
        chk("ram_alias", dmemrdata, 16'h5678);
        tick();
        drive(16'h0004, 1'b0, 1'b0, 16'h0000);
        chk("read_disabled", dmemrdata, 16'h0000);
        tick();

        drive(16'hFF00, 1'b0, 1'b1, 16'h00A5); tick();
        drive(16'hFF00, 1'b1, 1'b0, 16'h0000);
        chk("leds_a5", {8'h00, leds}, 16'h00A5);
        chk("led_read", dmemrdata, 16'h00A5);
        tick();
        switches = 8'h3C;
        for (int k = 0; k < 3; k++) begin
            drive(16'hFF02, 1'b1, 1'b0, 16'h0000);
            chk("sw_sync", dmemrdata, (k == 2) ? 16'h003C : 16'h0000);
            tick();
        end

        drive(16'hFF08, 1'b0, 1'b1, 16'h0014); tick();
        drive(16'hFF06, 1'b0, 1'b1, 16'h0010); tick();
        for (int k = 0; k < 7; k++) begin
            drive(16'hFF06, 1'b1, 1'b0, 16'h0000);
            chk("tcnt_run", dmemrdata, 16'h0010 + 16'(k));
            chk("flag_rise", {15'b0, timer_flag}, {15'b0, k >= 5});
            tick();
        end
        drive(16'hFF08, 1'b0, 1'b1, 16'h0022); tick();
        drive(16'hFF06, 1'b0, 1'b1, 16'h0020); tick();
        drive(16'hFF06, 1'b1, 1'b0, 16'h0000);
        chk("tcnt_reload", dmemrdata, 16'h0020);
        tick();
        tick();
        drive(16'hFF0A, 1'b0, 1'b1, 16'h0001); tick();
        drive(16'hFF0A, 1'b1, 1'b0, 16'h0000);
        chk("flag_set_wins", dmemrdata, 16'h0001);
        tick();
        drive(16'hFF0A, 1'b0, 1'b1, 16'h0001); tick();
        drive(16'hFF0A, 1'b1, 1'b0, 16'h0000);
        chk("flag_cleared", dmemrdata, 16'h0000);
        tick();

        drive(16'hFF04, 1'b1, 1'b0, 16'h0000);
        button = 1'b1; repeat (3) tick();
        button = 1'b0; repeat (8) tick();
        chk("btn_glitch", dmemrdata, 16'h0000);
        button = 1'b1; repeat (10) tick();
        chk("btn_press", dmemrdata, 16'h0003);
        drive(16'hFF04, 1'b0, 1'b1, 16'h0002); tick();
        drive(16'hFF04, 1'b1, 1'b0, 16'h0000);
        chk("btn_sticky_clear", dmemrdata, 16'h0001);
        button = 1'b0; repeat (10) tick();
        chk("btn_release", dmemrdata, 16'h0000);

        drive(16'hFF00, 1'b0, 1'b1, 16'h0011); tick();
        drive(16'hFF00, 1'b1, 1'b1, 16'h0022);
        chk("rw_same_cycle_old", dmemrdata, 16'h0011);
        tick();
        drive(16'hFF00, 1'b1, 1'b0, 16'h0000);
        chk("rw_same_cycle_new", dmemrdata, 16'h0022);
        tick();

        wrap_exp[0] = 16'hFFFE; wrap_exp[1] = 16'hFFFF; wrap_exp[2] = 16'h0000;
        drive(16'hFF06, 1'b0, 1'b1, 16'hFFFE); tick();
        for (int k = 0; k < 3; k++) begin
            drive(16'hFF06, 1'b1, 1'b0, 16'h0000);
            chk("tcnt_wrap", dmemrdata, wrap_exp[k]);
            tick();
        end

        for (int i = 0; i < 600; i++) begin
            logic [15:0] a;
            if ($urandom_range(0, 1) == 0) a = 16'($urandom_range(0, 16'hFEFF));
            else a = {8'hFF, 8'($urandom)};
            reset = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 5) == 0) button = ~button;
            if ($urandom_range(0, 9) == 0) switches = 8'($urandom);
            drive(a, 1'($urandom), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom));
            tick();
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
